// File: rtl/gdo_pkg.sv
// gdo_pkg: shared definitions for the sequential general data operator.
//   - operation encodings carried on in_op
//   - FSM state type
//   - helpers for signed max/min and the fixed-point 1.0 value
// Build option: GDO_SATURATE_EN (read by gdo_fx_mult and gdo_seq_operator).
package gdo_pkg;

    localparam logic [1:0] GDO_OP_ADD  = 2'd0;
    localparam logic [1:0] GDO_OP_SUB  = 2'd1;
    localparam logic [1:0] GDO_OP_MULT = 2'd2;
    localparam logic [1:0] GDO_OP_POW  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } gdo_state_e;

    // Results are returned at 64 bits; callers size-cast to WIDTH.
    function automatic logic [63:0] gdo_smax(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] gdo_smin(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] gdo_one(input int unsigned frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/gdo_fx_mult.sv
// gdo_fx_mult: combinational signed fixed-point multiply.
//   a, b  : WIDTH-bit two's complement Q(WIDTH-FRAC).FRAC operands
//   y     : product >>> FRAC, wrapped to WIDTH bits (or clamped when
//           GDO_SATURATE_EN is defined)
//   ovf   : shifted product does not fit the signed WIDTH range
module gdo_fx_mult
    import gdo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int unsigned PW = 2 * WIDTH;

`ifdef GDO_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(gdo_smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(gdo_smin(WIDTH));
`endif

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] shifted;

    always_comb begin
        prod    = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        // Arithmetic shift truncates toward minus infinity.
        shifted = prod >>> FRAC;
        // Fits iff every bit from the WIDTH sign position upward agrees.
        ovf     = !((&shifted[PW-1:WIDTH-1]) || !(|shifted[PW-1:WIDTH-1]));
        y       = shifted[WIDTH-1:0];
`ifdef GDO_SATURATE_EN
        if (ovf) begin
            y = shifted[PW-1] ? SMIN : SMAX;
        end
`endif
    end

endmodule

// File: rtl/gdo_seq_operator.sv
// gdo_seq_operator: sequential fixed-point ADD/SUB/MULT/POW over valid/ready.
//   clk, rst (sync, active high)
//   in_valid/in_ready/in_op/in_a/in_b : request (one op in flight at a time)
//   out_valid/out_ready/out_data/out_ovf : result, held until retired
// ADD/SUB/MULT finish in one cycle; POW iterates square-and-multiply.
// Build option: GDO_SATURATE_EN clamps overflowing results instead of wrapping.
module gdo_seq_operator
    import gdo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned FRAC  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(gdo_one(FRAC));
`ifdef GDO_SATURATE_EN
    localparam logic [WIDTH-1:0] SMAX = WIDTH'(gdo_smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(gdo_smin(WIDTH));
    logic neg_q, neg_d;
`endif

    gdo_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] base_q, base_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             base_bad_q, base_bad_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_ovf_q, out_ovf_d;

    logic [WIDTH-1:0] mul_a, mul_b, mul_y, sq_y;
    logic             mul_ovf, sq_ovf;
    logic [WIDTH-1:0] exp_in;
    logic [WIDTH:0]   addsub;

    // Acc path doubles as the MULT datapath while idle.
    assign mul_a = (state_q == StCalc) ? acc_q  : in_a;
    assign mul_b = (state_q == StCalc) ? base_q : in_b;

    gdo_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_acc_mult (
        .a   (mul_a),
        .b   (mul_b),
        .y   (mul_y),
        .ovf (mul_ovf)
    );

    gdo_fx_mult #(.WIDTH(WIDTH), .FRAC(FRAC)) u_sq_mult (
        .a   (base_q),
        .b   (base_q),
        .y   (sq_y),
        .ovf (sq_ovf)
    );

    assign exp_in = $unsigned($signed(in_b) >>> FRAC);
    assign addsub = (in_op == GDO_OP_SUB) ? {in_a[WIDTH-1], in_a} - {in_b[WIDTH-1], in_b}
                                          : {in_a[WIDTH-1], in_a} + {in_b[WIDTH-1], in_b};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        base_d     = base_q;
        exp_d      = exp_q;
        base_bad_d = base_bad_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
`ifdef GDO_SATURATE_EN
        neg_d      = neg_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StDone;
                    case (in_op)
                        GDO_OP_ADD, GDO_OP_SUB: begin
                            out_data_d = addsub[WIDTH-1:0];
                            out_ovf_d  = addsub[WIDTH] ^ addsub[WIDTH-1];
`ifdef GDO_SATURATE_EN
                            if (out_ovf_d) out_data_d = addsub[WIDTH] ? SMIN : SMAX;
`endif
                        end
                        GDO_OP_MULT: begin
                            out_data_d = mul_y;
                            out_ovf_d  = mul_ovf;
                        end
                        GDO_OP_POW: begin
                            if (in_b[WIDTH-1]) begin
                                out_data_d = '0;
                                out_ovf_d  = 1'b1;
                            end else if (exp_in == '0) begin
                                out_data_d = ONE;
                                out_ovf_d  = 1'b0;
                            end else begin
                                // out_ovf doubles as the sticky POW flag while calculating.
                                state_d    = StCalc;
                                acc_d      = ONE;
                                base_d     = in_a;
                                exp_d      = exp_in;
                                base_bad_d = 1'b0;
                                out_ovf_d  = 1'b0;
`ifdef GDO_SATURATE_EN
                                neg_d      = in_a[WIDTH-1] & exp_in[0];
`endif
                            end
                        end
                        default: ;
                    endcase
                end
            end
            StCalc: begin
                if (exp_q[0]) begin
                    acc_d     = mul_y;
                    out_ovf_d = out_ovf_q | mul_ovf | base_bad_q;
                end
                base_d     = sq_y;
                base_bad_d = base_bad_q | sq_ovf;
                exp_d      = exp_q >> 1;
                if (exp_d == '0) begin
                    state_d    = StDone;
                    out_data_d = acc_d;
`ifdef GDO_SATURATE_EN
                    if (out_ovf_d) out_data_d = neg_q ? SMIN : SMAX;
`endif
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            base_q     <= '0;
            exp_q      <= '0;
            base_bad_q <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
`ifdef GDO_SATURATE_EN
            neg_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            exp_q      <= exp_d;
            base_bad_q <= base_bad_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
`ifdef GDO_SATURATE_EN
            neg_q      <= neg_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: doc/gdo_seq_operator.md
# gdo_seq_operator

Sequential, parametrised fixed-point operator for the neural datapath; successor to the combinational general data operator functions (add/sub/mult/pow). It accepts one operation at a time over a valid/ready handshake on signed Q(WIDTH−FRAC).FRAC operands. ADD/SUB/MULT complete in one cycle; POW is computed iteratively by square-and-multiply. The result is WIDTH bits with an overflow flag.

## Interface
- WIDTH, 8, operand/result width in bits (two's complement), ≥ 4
- FRAC, 4, fractional bits, 0 ≤ FRAC ≤ WIDTH−2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept
- in_op  in  2  0=ADD, 1=SUB, 2=MULT, 3=POW
- in_a  in  WIDTH  operand a (base for POW)
- in_b  in  WIDTH  operand b (exponent for POW)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  result
- out_ovf  out  1  overflow or illegal-exponent flag for this result

## Operation
- Accept when in_valid && in_ready; operands and op are latched, and the inputs are then don't-care.
- ADD: a+b. SUB: a−b. Both are computed at WIDTH+1 bits; overflow if the result exceeds the signed WIDTH range.
- MULT: full 2·WIDTH product, arithmetic shift right by FRAC (truncation toward −∞); overflow if the shifted value is outside the signed WIDTH range.
- POW: exponent e = integer part of b (b >>> FRAC); the fractional bits of b are ignored.
  - b negative: out_data=0, out_ovf=1.
  - e=0: out_data = 1.0 (1<<FRAC), out_ovf=0.
  - Otherwise: acc=1.0, base=a; each iteration, if the LSB of the remaining exponent is 1 then acc=acc·base; then base=base·base; exponent >>=1; stop when the remaining exponent is 0.
  - Each multiply uses the MULT rule. A squaring overflow marks base_bad. out_ovf is set only if an acc multiply overflows or consumes a base_bad base (sticky).
- FSM states:
  - IDLE → CALC on accepted POW with e≠0.
  - IDLE → DONE on other accepts.
  - CALC → DONE when the remaining exponent is 0.
  - DONE → IDLE on out_ready.
- in_ready = (state==IDLE).
- out_valid = (state==DONE). out_data and out_ovf are held stable while out_valid && !out_ready.

## Timing
- Reset values: state=IDLE, in_ready=1 in the cycle after reset, out_valid=0, out_data=0, out_ovf=0.
- ADD/SUB/MULT and POW with e=0 or b<0: out_valid rises 1 cycle after accept.
- POW with e>0: out_valid rises 1+k cycles after accept, where k = index of the highest set bit of e, plus 1. Maximum is WIDTH−FRAC cycles.
- The next accept is possible in the cycle after the out_valid && out_ready handshake (no same-cycle accept/retire; throughput ≤ 1 op per 2 cycles).
- rst mid-CALC or mid-DONE: the operation is discarded, there is no output, and the reset values apply.

## Configuration
- GDO_SATURATE_EN defined:
  - On overflow, out_data clamps to the signed max (0111…1) or min (1000…0) according to the sign of the exact result.
  - In POW, once an acc overflow or base_bad occurs, the result is clamped using the sign of the true result: negative iff a<0 and e odd.
- GDO_SATURATE_EN undefined:
  - out_data is the low WIDTH bits of the computed value (wrap-around).
  - POW continues with wrapped intermediates.
- out_ovf behaves identically in both builds.

## Structure
- Package gdo_pkg:
  - op encoding constants (GDO_OP_ADD/SUB/MULT/POW)
  - FSM state typedef
  - helper constants for signed max/min and one-value as functions of WIDTH/FRAC
- Sub-module gdo_fx_mult:
  - combinational WIDTH×WIDTH signed fixed-point multiply with shift, range check, and optional saturation
  - instantiated twice: acc path and square path
  - MULT reuses the acc instance

## Test plan
- WIDTH=8, FRAC=4, saturation on: ADD 0xF8+0x08 → 0x00, ovf=0, 1-cycle latency; ADD 0x70+0x20 → 0x7F, ovf=1.
- SUB 0x08−0x08 → 0x00; MULT 0xF8·0x08 (−0.5·0.5) → 0xFC, ovf=0.
- POW 0x18^0x20 (1.5²) → 0x24, ovf=0, latency 3. POW 0x20^0x30 (2³) → 0x7F, ovf=1, and 0x80 in the build without GDO_SATURATE_EN. POW x^0x0C (e=0) → 0x10. POW x^0xF0 → 0x00, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles; out_data stays stable and in_ready=0. A new in_valid is ignored until the cycle after retire.
- Assert rst during CALC of POW 0x18^0x70; next cycle out_valid=0, in_ready=1; a subsequent ADD completes correctly.
- Random ops versus a reference model for WIDTH=12, FRAC=6; check results, ovf, and latency formula.
